dmem_arbiter: RTL and testbench

Two-master arbiter sharing the single data-memory/memory-mapped-IO slave between the CPU load/store port (master 0) and a secondary bus master such as a DMA or debug loader (master 1). It sits in front of the data-memory block. It owns req/ack handshakes, round-robin arbitration, latching of the winning request, and read-data return. It also decodes the IO window bit so the slave's DRAM-vs-IO split stays consistent for both masters.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_arbiter_rr_arb2.sv | 24 ++
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional statistics counters are enabled with DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 7;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the master not served last wins.
// Purely combinational.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic gnt_valid,
  output logic gnt_id
);

  assign gnt_valid = req0 | req1;

  always_comb begin
    gnt_id = M_CPU;
    unique case (1'b1)
      (req0 && req1):  gnt_id = ~last_gnt;
      (req1 && !req0): gnt_id = M_AUX;
      default:         gnt_id = M_CPU;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the data-memory / IO slave.
// Define DMEM_ARB_STATS_EN to add grant and conflict counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1,
  parameter int IO_BIT = 7
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_io_sel,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   gnt_cnt0,
  output logic [15:0]   gnt_cnt1,
  output logic [15:0]   conflict_cnt
`endif
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_lat_chk
    $error("dmem_arbiter: RD_LAT must be within 1..7");
  end

  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  state_t        r_state;
  logic [2:0]    r_cnt;
  logic          r_last_gnt;
  logic          r_gnt_id;
  logic          r_mem_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_io_sel;
  logic [DW-1:0] r_rbuf;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic          r_ack0;
  logic          r_ack1;

  logic          w_gnt_valid;
  logic          w_gnt_id;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_we;

  rr_arb2 u_rr (
    .req0     (m0_req),
    .req1     (m1_req),
    .last_gnt (r_last_gnt),
    .gnt_valid(w_gnt_valid),
    .gnt_id   (w_gnt_id)
  );

  assign w_addr  = w_gnt_id ? m1_addr  : m0_addr;
  assign w_wdata = w_gnt_id ? m1_wdata : m0_wdata;
  assign w_we    = w_gnt_id ? m1_we    : m0_we;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_last_gnt <= M_AUX;
      r_gnt_id   <= M_CPU;
      r_mem_we   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_io_sel   <= 1'b0;
      r_rbuf     <= '0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
    end else begin
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_mem_we <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_gnt_id <= w_gnt_id;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_io_sel <= w_addr[IO_BIT];
            r_mem_we <= w_we;
            r_cnt    <= LAT_M1;
            r_state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt == 3'd0) begin
            r_rbuf  <= mem_rdata;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        RESP: begin
          if (r_gnt_id == M_AUX) begin
            r_ack1   <= 1'b1;
            r_rdata1 <= r_rbuf;
          end else begin
            r_ack0   <= 1'b1;
            r_rdata0 <= r_rbuf;
          end
          r_last_gnt <= r_gnt_id;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m0_ack     = r_ack0;
  assign m1_ack     = r_ack1;
  assign m0_rdata   = r_rdata0;
  assign m1_rdata   = r_rdata1;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_we     = r_mem_we;
  assign mem_io_sel = r_io_sel;
  assign busy       = (r_state != IDLE);

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_gc0;
  logic [15:0] r_gc1;
  logic [15:0] r_cc;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_gc0 <= '0;
      r_gc1 <= '0;
      r_cc  <= '0;
    end else if (r_state == IDLE) begin
      if (w_gnt_valid && w_gnt_id == M_CPU) r_gc0 <= sat_inc(r_gc0);
      if (w_gnt_valid && w_gnt_id == M_AUX) r_gc1 <= sat_inc(r_gc1);
      if (m0_req && m1_req) r_cc <= sat_inc(r_cc);
    end
  end

  assign gnt_cnt0     = r_gc0;
  assign gnt_cnt1     = r_gc1;
  assign conflict_cnt = r_cc;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed + random transactions vs a transaction-level model.
// A second instance with RD_LAT=3 checks the capture point of slave data.
module tb_dmem_arbiter;

  localparam int LAT = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_io_sel, busy;

  logic        b_req;
  logic [31:0] b_addr;
  logic        b_ack, b_m1_ack, b_we_o, b_io, b_busy;
  logic [31:0] b_rdata, b_m1_rdata, b_maddr, b_mwdata;
  logic [31:0] cyc = 32'd0;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
  logic [15:0] b_gc0, b_gc1, b_cc;
`endif

  always #5 clock = ~clock;

  dmem_arbiter #(.RD_LAT(LAT)) u_dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_io_sel(mem_io_sel), .mem_rdata(mem_rdata), .busy(busy)
`ifdef DMEM_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .conflict_cnt(conflict_cnt)
`endif
  );

  dmem_arbiter #(.RD_LAT(3)) u_dut3 (
    .clock(clock), .reset(reset),
    .m0_req(b_req), .m0_we(1'b0), .m0_addr(b_addr), .m0_wdata(32'd0),
    .m0_ack(b_ack), .m0_rdata(b_rdata),
    .m1_req(1'b0), .m1_we(1'b0), .m1_addr(32'd0), .m1_wdata(32'd0),
    .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_we(b_we_o),
    .mem_io_sel(b_io), .mem_rdata(cyc), .busy(b_busy)
`ifdef DMEM_ARB_STATS_EN
    , .gnt_cnt0(b_gc0), .gnt_cnt1(b_gc1), .conflict_cnt(b_cc)
`endif
  );

  // Slave: word memory; unwritten words read a fixed pattern of their index.
  logic [31:0] slave_mem [64];
  logic        written   [64];
  logic [31:0] ref_mem   [64];

  function automatic logic [31:0] init_val(input int idx);
    return (idx * 32'h9E3779B9) ^ 32'h00001234;
  endfunction

  always @(posedge clock) begin
    cyc <= cyc + 32'd1;
    if (mem_we) begin
      slave_mem[mem_addr[7:2]] <= mem_wdata;
      written[mem_addr[7:2]]   <= 1'b1;
    end
  end

  assign mem_rdata = written[mem_addr[7:2]] ? slave_mem[mem_addr[7:2]]
                                             : init_val(int'(mem_addr[7:2]));

  int n_chk  = 0;
  int n_fail = 0;
  bit model_last = 1'b1;
  int exp_g0 = 0, exp_g1 = 0, exp_conf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic round(input bit q0, input bit q1,
                       input logic we0, input logic we1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    bit p0, p1, win, got;
    int n, wecnt;
    logic        wwe;
    logic [31:0] wa, wd;
    m0_req = q0; m0_we = we0; m0_addr = a0; m0_wdata = d0;
    m1_req = q1; m1_we = we1; m1_addr = a1; m1_wdata = d1;
    p0 = q0; p1 = q1;
    if (q0 && q1) exp_conf++;
    while (p0 || p1) begin
      win = (p0 && p1) ? ~model_last : p1;
      wwe = win ? we1 : we0;
      wa  = win ? a1 : a0;
      wd  = win ? d1 : d0;
      n = 0; got = 1'b0; wecnt = 0;
      while (!got && n < 20) begin
        @(posedge clock); #1;
        n++;
        if (mem_we) wecnt++;
        if (n == 1) begin
          if (win) begin
            m1_addr = $urandom; m1_wdata = $urandom; m1_we = ~we1;
          end else begin
            m0_addr = $urandom; m0_wdata = $urandom; m0_we = ~we0;
          end
        end
        got = m0_ack | m1_ack;
      end
      chk("latency", n, LAT + 2);
      chk("ack_id", {30'd0, m1_ack, m0_ack}, win ? 32'd2 : 32'd1);
      chk("mem_addr", mem_addr, wa);
      chk("io_sel", {31'd0, mem_io_sel}, {31'd0, wa[7]});
      chk("we_pulses", wecnt, wwe ? 32'd1 : 32'd0);
      if (wwe) begin
        chk("mem_wdata", mem_wdata, wd);
        ref_mem[wa[7:2]] = wd;
      end else begin
        chk("rdata", win ? m1_rdata : m0_rdata, ref_mem[wa[7:2]]);
      end
      if (win) begin
        m1_req = 1'b0; p1 = 1'b0; exp_g1++;
      end else begin
        m0_req = 1'b0; p0 = 1'b0; exp_g0++;
      end
      model_last = win;
    end
    @(posedge clock); #1;
    chk("ack_pulse", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] c0;
    for (int i = 0; i < 64; i++) begin
      written[i] = 1'b0;
      ref_mem[i] = init_val(i);
    end
    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    b_req = 0; b_addr = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("rst_rdata0", m0_rdata, 32'd0);
    chk("rst_rdata1", m1_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_we_io_busy", {29'd0, mem_we, mem_io_sel, busy}, 32'd0);
    reset = 1'b0;

    // Directed: CPU read of a known word
    slave_mem[4] = 32'hDEADBEEF; written[4] = 1'b1; ref_mem[4] = 32'hDEADBEEF;
    round(1, 0, 0, 0, 32'h10, 0, 0, 0);
    chk("m0_read_data", m0_rdata, 32'hDEADBEEF);
    // Directed: aux write into the IO window
    round(0, 1, 0, 1, 0, 32'h84, 0, 32'h5A);
    // Alternation under continuous conflict
    for (int i = 0; i < 4; i++)
      round(1, 1, 0, 0, 32'h10, 32'h84, 0, 0);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      round(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom, $urandom, $urandom);
    end

    // RD_LAT=3 instance: data must come from the third ACCESS cycle
    b_req = 1'b1; b_addr = 32'h20; c0 = cyc;
    n = 0;
    while (!b_ack && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    b_req = 1'b0;
    chk("lat3_latency", n, 32'd5);
    chk("lat3_rdata", b_rdata, c0 + 32'd3);

`ifdef DMEM_ARB_STATS_EN
    chk("conflict_cnt", {16'd0, conflict_cnt}, exp_conf);
    chk("gnt_cnt0", {16'd0, gnt_cnt0}, exp_g0);
    chk("gnt_cnt1", {16'd0, gnt_cnt1}, exp_g1);
`endif

    // Reset during ACCESS of an aux write
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h88; m1_wdata = 32'hCAFE;
    @(posedge clock); #1;
    chk("pre_rst_we", {30'd0, mem_we, busy}, 32'd3);
    reset = 1'b1; m1_req = 1'b0;
    @(posedge clock); #1;
    chk("abort_we_busy", {30'd0, mem_we, busy}, 32'd0);
    chk("abort_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("abort_rdata1", m1_rdata, 32'd0);
`ifdef DMEM_ARB_STATS_EN
    chk("stats_rst", {conflict_cnt, gnt_cnt0 | gnt_cnt1}, 32'd0);
`endif
    reset = 1'b0;
    model_last = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      chk("abort_no_ack", {30'd0, m1_ack, busy}, 32'd0);
    end
    round(1, 1, 0, 0, 32'h0, 32'h4, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
